// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, fetch FSM encoding and the
// {pc, instr} entry carried from memory response to decoder.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with a flush that wins over any same-cycle push/pop.
// Storage resets to zero so the head reads as zero out of reset.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign do_pop  = pop && (cnt_q != '0) && !flush;
    assign do_push = push && !flush && ((cnt_q != FULL_CNT) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a small buffer, and redirect flush with drain of stale responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] CREDITS = CW1'(DEPTH);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   buf_count, pcq_count;
    logic            req_fire, rsp_ret, rsp_take, inst_fire;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    rsp_entry, head_entry;

    // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
    assign imem_req_valid = (state_q == ST_FETCH)
                         && (({1'b0, buf_count} + {1'b0, outst_q}) < CREDITS)
                         && !redirect_valid;
    assign imem_addr = pc_q;
    assign req_fire  = imem_req_valid && imem_req_ready;

    assign rsp_ret   = imem_rsp_valid && (outst_q != '0);
    assign rsp_take  = imem_rsp_valid && (state_q == ST_FETCH) && !redirect_valid
                    && (pcq_count != '0);
    assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    assign inst_valid  = (buf_count != '0);
    assign inst_fire   = inst_valid && inst_ready;
    assign instruction = head_entry.instr;
    assign inst_pc     = head_entry.pc;

    always_comb begin
        outst_d = outst_q;
        if (req_fire && !rsp_ret) begin
            outst_d = outst_q + CW'(1);
        end else if (!req_fire && rsp_ret) begin
            outst_d = outst_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (redirect_valid && (outst_d != '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (outst_d == '0) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
        end
    end

    // PC of each in-flight request, paired with its response on return.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_take),
        .head      (rsp_pc),
        .count     (pcq_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_take),
        .push_data (rsp_entry),
        .pop       (inst_fire),
        .head      (head_entry),
        .count     (buf_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; also the credit limit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_addr  output  32  fetch address, word-aligned.
REQ-008 imem_rsp_valid  input  1  response valid; in order, never stalled.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from downstream.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 inst_valid  output  1  instruction available to the decoder.
REQ-013 inst_ready  input  1  decoder consumes instruction.
REQ-014 instruction  output  32  instruction word to the B-type/other decoders.
REQ-015 inst_pc  output  32  PC of the instruction.

Function
REQ-016 FSM states: BOOT, FETCH, DRAIN.
- BOOT->FETCH unconditionally after 1 cycle.
- FETCH->DRAIN on redirect with outstanding != 0 (after counting any same-cycle accepted request).
- DRAIN->FETCH in the cycle the last outstanding response arrives.
REQ-017 Request handshake: occurs when imem_req_valid && imem_req_ready. imem_req_valid = (state==FETCH) && (count + outstanding < DEPTH) && !redirect_valid.
REQ-018 imem_addr equals pc. pc += 4 on each request handshake, wrapping modulo 2^32.
REQ-019 While imem_req_valid is high without ready, addr stays stable; the only exception is redirect, which may withdraw or change the request.
REQ-020 outstanding counter: +1 on request handshake, -1 on response. Simultaneous handshake and response leave it unchanged. It never exceeds DEPTH.
REQ-021 Response capture: in FETCH, a response is written into the buffer as {pc_of_request, data}, in order. Responses arriving in DRAIN, or in the same cycle as redirect, are discarded.
REQ-022 Buffer is a FIFO of DEPTH entries. inst_valid = (count != 0). instruction and inst_pc come from the head entry.
REQ-023 Consume: on inst_valid && inst_ready, the head is popped. Simultaneous push and pop keep count constant.
REQ-024 Latency: response captured at edge N gives inst_valid high after edge N (registered). First request is issued in the cycle after BOOT.
REQ-025 Redirect (any state):
- FIFO cleared.
- pc <= {redirect_pc[31:2], 2'b00}.
- A same-cycle inst handshake still counts as delivered.
- Redirect in DRAIN updates pc and stays in DRAIN.
REQ-026 Per-request PC tracking: a DEPTH-entry in-order PC queue, cleared on redirect.
REQ-027 A full buffer blocks new requests via the credit rule; no response is ever lost in FETCH.

Reset
REQ-028 Asserting rst_n low immediately (asynchronously) sets:
- state=BOOT, pc=RESET_PC, count=0, outstanding=0.
- imem_req_valid=0, inst_valid=0, instruction=0, inst_pc=0.
REQ-029 Reset mid-transaction abandons in-flight responses; no response after reset release is attributed to pre-reset requests (the environment guarantees memory reset too).

Structure
REQ-030 Shared package riscv_pkg holds:
- XLEN=32, ILEN=32.
- fetch state encoding (BOOT/FETCH/DRAIN).
- fetch entry type {pc, instr}.
- RESET_PC default.
REQ-031 One sub-module, fetch_fifo (parameterised width/depth, flush input), instantiated for the instruction buffer.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory latency, inst_ready=1 -> addresses 0x0,0x4,0x8 issued back-to-back; instruction/inst_pc pairs appear in order, one cycle after each response.
REQ-033 inst_ready=0 with DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0. Raising inst_ready yields 0x0 then 0x4, and fetching resumes at 0x8.
REQ-034 redirect_pc=0x0000_0103 with 2 outstanding -> state DRAIN, both responses discarded, next request address 0x0000_0100, first delivered inst_pc=0x100.
REQ-035 pc=0xFFFF_FFFC request handshake -> next imem_addr=0x0000_0000 (wrap).
REQ-036 Redirect in the same cycle as a response and an inst handshake -> response dropped, FIFO empty next cycle, handshaken instruction not re-presented.
REQ-037 rst_n asserted low mid-stream, asynchronously -> outputs at reset values before the next clk edge; restart fetch at RESET_PC.
